kyber_indcpa_dec_sequencer: RTL
===============================

Name: kyber_indcpa_dec_sequencer

Overview:
Top-level controller for the IND-CPA decryption datapath. It launches the decrypt stages strictly in order: ciphertext unpack, inverse NTT, poly subtract, reduce, poly-to-message. Each stage is started with a one-cycle enable pulse, and the sequencer waits for that stage's done before moving on. When the last stage completes it captures the 256-bit message. It also provides per-stage watchdog, abort and cycle-count instrumentation for the AXI wrapper.

Parameters:
NUM_STAGES, 5, number of sequenced stages; index NUM_STAGES-1 is the poly-to-message stage.
IDX_W, 3, width of the stage index and err_stage; must satisfy 2^IDX_W >= NUM_STAGES.
TIMEOUT, 4096, maximum cycles in WAIT per stage before a fault is declared.
MSG_W, 256, message width in bits.

Ports:
clk  input  1  clock.
rst_n  input  1  reset: asynchronous, active-low.
start  input  1  request a decrypt run; honoured only in IDLE or FAULT.
abort  input  1  cancel the run in progress.
stage_done  input  NUM_STAGES  per-stage done (level; may remain high after completion).
tomsg_msg  input  MSG_W  message bus from the poly-to-message stage.
stage_en  output  NUM_STAGES  one-hot, one-cycle start pulse to each stage.
msg_out  output  MSG_W  captured message.
msg_valid  output  1  msg_out holds the result of the last completed run.
busy  output  1  high in LAUNCH, WAIT and CAPTURE.
done  output  1  one-cycle completion pulse.
error  output  1  watchdog fault flag (sticky).
err_stage  output  IDX_W  index of the stage that timed out.
cycle_count  output  32  cycles spent in LAUNCH/WAIT during the last run.

Behaviour:
- Reset: FSM goes to IDLE. All outputs and internal registers are 0: idx, watchdog, edge-detect registers done_q.
- States:
  - IDLE.
  - LAUNCH: stage_en[idx]=1 for exactly this cycle; watchdog cleared.
  - WAIT.
  - CAPTURE: done=1.
  - FAULT.
- All outputs are decoded from registered state. stage_en is 0 outside LAUNCH.
- Done edge detection: done_q <= stage_done every cycle. A stage completes only on a rising edge, stage_done[idx] & ~done_q[idx], sampled in WAIT.
  - A stale high level left over from a previous run is ignored.
  - Done from any stage other than idx is ignored.
  - Done in the LAUNCH cycle is ignored; stages have latency >= 1.
- IDLE/FAULT with start=1 and abort=0 goes to LAUNCH with idx=0. On the same edge: cycle_count=0, msg_valid=0, error=0, err_stage=0.
- LAUNCH goes to WAIT.
- WAIT with rising edge:
  - idx < NUM_STAGES-1: idx+1 and go to LAUNCH.
  - idx = NUM_STAGES-1: msg_out <= tomsg_msg, msg_valid <= 1, go to CAPTURE.
- WAIT with no edge: watchdog+1. When watchdog == TIMEOUT-1, go to FAULT with error=1 and err_stage=idx.
- The done edge wins over timeout in the same cycle.
- CAPTURE goes to IDLE. msg_valid and msg_out are held until the next accepted start.
- FAULT: busy=0, error held. Leaves only on start (as from IDLE) or reset.
- cycle_count: +1 each cycle in LAUNCH or WAIT. Saturates at 0xFFFFFFFF. Frozen outside a run.
- abort in LAUNCH/WAIT/CAPTURE goes to IDLE next edge.
  - No done pulse, msg_valid stays 0, error unchanged.
  - abort has priority over done edge, timeout and capture in the same cycle.
  - abort in IDLE or FAULT: no effect. start and abort together in IDLE: abort wins, start ignored.
- start while busy is ignored. It is not queued.
- Reset mid-run: immediate return to IDLE, all outputs 0.

Test Plan:
- Nominal run: start=1 in cycle 0. Model each stage with done rising 2 cycles after its en, and tomsg_msg=0xA5…A5.
  - Required: stage_en pulses in cycles 1,4,7,10,13.
  - Required: done=1 and msg_out=0xA5…A5, msg_valid=1 in cycle 16. busy high in cycles 1–16.
  - Required: cycle_count=15.
- Stale done: hold stage_done[0]=1 from a prior run through start. Stage 0 model must drop done and raise it again.
  - Required: the sequencer does not advance until the new rising edge, and exactly one stage_en[1] pulse.
- Timeout: stage 2 never asserts done, TIMEOUT=16.
  - Required: error=1, err_stage=2, busy=0 exactly 16 cycles after stage_en[2]. No done.
  - Required: a subsequent start clears error and reruns from stage 0.
- Abort: assert abort in the same cycle as the stage-3 done edge.
  - Required: IDLE next cycle, no stage_en[4], done never asserted, msg_valid=0.
- Start while busy / start+abort: pulse start mid-run, then start+abort together in IDLE.
  - Required: the mid-run start has no effect on stage_en. The combined pulse produces no launch.
- Reset mid-run: drop rst_n during WAIT on stage 1.
  - Required: all outputs 0 asynchronously. After reset release, the next start runs normally from stage 0.

Source files
------------

// File: rtl/kyber_indcpa_dec_sequencer.sv
// Ordered launcher for the IND-CPA decrypt stages with watchdog, abort and cycle instrumentation.
// Latency: one cycle per LAUNCH, plus stage latency in WAIT; no backpressure, start ignored while busy.
module kyber_indcpa_dec_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int IDX_W      = 3,
  parameter int TIMEOUT    = 4096,
  parameter int MSG_W      = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic [MSG_W-1:0]      tomsg_msg,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [MSG_W-1:0]      msg_out,
  output logic                  msg_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      err_stage,
  output logic [31:0]           cycle_count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [WD_W-1:0]       WD_LIMIT = WD_W'(TIMEOUT - 1);
  localparam logic [NUM_STAGES-1:0] EN_FIRST = NUM_STAGES'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CAPTURE,
    S_FAULT
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [WD_W-1:0]       watchdog;
  logic [WD_W-1:0]       wd_next;
  logic [NUM_STAGES-1:0] done_q;
  logic                  done_edge;

  // Only a fresh rising edge on the active stage counts; stale levels are ignored.
  assign done_edge = stage_done[idx] & ~done_q[idx];
  assign wd_next   = watchdog + WD_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      watchdog    <= '0;
      done_q      <= '0;
      stage_en    <= '0;
      msg_out     <= '0;
      msg_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_stage   <= '0;
      cycle_count <= '0;
    end else begin
      done_q   <= stage_done;
      stage_en <= '0;
      done     <= 1'b0;

      if ((state == S_LAUNCH || state == S_WAIT) && cycle_count != 32'hFFFF_FFFF)
        cycle_count <= cycle_count + 32'd1;

      case (state)
        S_IDLE, S_FAULT: begin
          if (start && !abort) begin
            state       <= S_LAUNCH;
            idx         <= '0;
            watchdog    <= '0;
            stage_en    <= EN_FIRST;
            busy        <= 1'b1;
            cycle_count <= '0;
            msg_valid   <= 1'b0;
            error       <= 1'b0;
            err_stage   <= '0;
          end
        end

        S_LAUNCH: begin
          watchdog <= '0;
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (done_edge) begin
            watchdog <= '0;
            if (idx == LAST_IDX) begin
              msg_out   <= tomsg_msg;
              msg_valid <= 1'b1;
              done      <= 1'b1;
              state     <= S_CAPTURE;
            end else begin
              idx      <= idx + IDX_W'(1);
              stage_en <= EN_FIRST << (idx + IDX_W'(1));
              state    <= S_LAUNCH;
            end
          end else if (wd_next == WD_LIMIT) begin
            state     <= S_FAULT;
            error     <= 1'b1;
            err_stage <= idx;
            busy      <= 1'b0;
          end else begin
            watchdog <= wd_next;
          end
        end

        S_CAPTURE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
